jtag_master: RTL

JTAG_MASTER -- requirements
Module: jtag_master

---
 rtl/jtag_pkg.sv | 56 +++++
 rtl/jtag_tck_gen.sv | 37 +++
 rtl/jtag_master.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: command opcodes, master FSM states, TMS header lengths and the per-TCK TMS table.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'b00,
    OP_IR_SCAN   = 2'b01,
    OP_DR_SCAN   = 2'b10,
    OP_RSVD      = 2'b11
  } jtag_op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HDR,
    ST_SHIFT,
    ST_TRL,
    ST_RTI,
    ST_RESP
  } jtag_state_e;

  localparam logic [7:0] HDR_LEN_DR    = 8'd3;
  localparam logic [7:0] HDR_LEN_IR    = 8'd4;
  localparam logic [7:0] HDR_LEN_RST   = 8'd5;
  localparam logic [7:0] INIT_TCKS     = 8'd6;
  localparam logic [7:0] INIT_TMS_HIGH = 8'd5;

  function automatic logic [7:0] hdr_len(input jtag_op_e op);
    case (op)
      OP_DR_SCAN: return HDR_LEN_DR;
      OP_IR_SCAN: return HDR_LEN_IR;
      default:    return HDR_LEN_RST;
    endcase
  endfunction

  // TMS for TCK number idx of state st; IDLE/RESP rest with TMS low (TAP parked in Run-Test/Idle).
  function automatic logic tck_tms(input jtag_state_e st, input logic [7:0] idx,
                                   input jtag_op_e op, input logic [5:0] len);
    logic tms;
    tms = 1'b0;
    case (st)
      ST_INIT: tms = (idx < INIT_TMS_HIGH);
      ST_HDR: begin
        case (op)
          OP_DR_SCAN: tms = (idx == 8'd0);
          OP_IR_SCAN: tms = (idx < 8'd2);
          default:    tms = 1'b1;
        endcase
      end
      ST_SHIFT: tms = (idx == ({2'b00, len} - 8'd1));
      ST_TRL:   tms = (op != OP_TAP_RESET) && (idx == 8'd0);
      default:  tms = 1'b0;
    endcase
    return tms;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider; o_rise/o_fall pulse for one CLK in the cycle whose edge moves TCK.
// TCK toggles every CLK_DIV cycles while i_en is high and is forced low otherwise.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tck,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] r_cnt;
  logic          r_tck;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tck  = r_tck;
  assign o_rise = w_tick & ~r_tck;
  assign o_fall = w_tick & r_tck;

endmodule

// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG TAP master (TAP reset / IR scan / DR scan); optional RTI wait via JTAG_MASTER_RTI_WAIT_EN.
// One command in flight; CmdReady only in IDLE, response held in RESP until RspReady.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CmdValid,
  output logic               CmdReady,
  input  logic [1:0]         CmdOp,
  input  logic [5:0]         CmdLen,
  input  logic [MAX_LEN-1:0] CmdData,
`ifdef JTAG_MASTER_RTI_WAIT_EN
  input  logic [7:0]         CmdIdle,
`endif
  output logic               RspValid,
  input  logic               RspReady,
  output logic [MAX_LEN-1:0] RspData,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               Busy
);
  localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

  jtag_state_e        r_state;
  jtag_op_e           r_op;
  logic [5:0]         r_len;
  logic [MAX_LEN-1:0] r_data;
  logic [MAX_LEN-1:0] r_rsp;
  logic [7:0]         r_idx;
  logic               r_tms;
  logic               r_tdi;
  logic               r_cmd_rdy;
  logic               r_rsp_vld;
  logic               r_busy;
`ifdef JTAG_MASTER_RTI_WAIT_EN
  logic [7:0]         r_idle;
`endif

  logic               w_tck_en;
  logic               w_tck;
  logic               w_rise;
  logic               w_fall;
  logic               w_bad;
  logic [7:0]         w_len;
  logic               w_last;
  jtag_state_e        w_nxt_state;
  logic [7:0]         w_nxt_idx;
  logic               w_nxt_tms;
  logic               w_nxt_tdi;
  logic [MAX_LEN-1:0] w_data_sh;

  assign w_tck_en = (r_state == ST_INIT) || (r_state == ST_HDR) || (r_state == ST_SHIFT) ||
                    (r_state == ST_TRL)  || (r_state == ST_RTI);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (w_tck_en),
    .o_tck   (w_tck),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_bad = (CmdLen == 6'd0) || (CmdLen > LEN_MAX) || (CmdOp == OP_RSVD);

  // Sequencing decision taken at each TCK falling edge: next state/bit and the TMS/TDI it needs.
  always_comb begin
    w_len = 8'd0;
    case (r_state)
      ST_INIT:  w_len = INIT_TCKS;
      ST_HDR:   w_len = hdr_len(r_op);
      ST_SHIFT: w_len = {2'b00, r_len};
      ST_TRL:   w_len = (r_op == OP_TAP_RESET) ? 8'd1 : 8'd2;
`ifdef JTAG_MASTER_RTI_WAIT_EN
      ST_RTI:   w_len = r_idle;
`endif
      default:  w_len = 8'd0;
    endcase
    w_last      = (r_idx == (w_len - 8'd1));
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx + 8'd1;
    if (w_last) begin
      w_nxt_idx = 8'd0;
      case (r_state)
        ST_INIT:  w_nxt_state = ST_IDLE;
        ST_HDR:   w_nxt_state = (r_op == OP_TAP_RESET) ? ST_TRL : ST_SHIFT;
        ST_SHIFT: w_nxt_state = ST_TRL;
`ifdef JTAG_MASTER_RTI_WAIT_EN
        ST_TRL:   w_nxt_state = (r_idle != 8'd0) ? ST_RTI : ST_RESP;
`else
        ST_TRL:   w_nxt_state = ST_RESP;
`endif
        ST_RTI:   w_nxt_state = ST_RESP;
        default:  w_nxt_state = r_state;
      endcase
    end
    w_nxt_tms = tck_tms(w_nxt_state, w_nxt_idx, r_op, r_len);
    w_data_sh = r_data >> w_nxt_idx;
    w_nxt_tdi = (w_nxt_state == ST_SHIFT) ? w_data_sh[0] : 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= ST_INIT;
      r_op      <= OP_TAP_RESET;
      r_len     <= 6'd0;
      r_data    <= '0;
      r_rsp     <= '0;
      r_idx     <= 8'd0;
      r_tms     <= 1'b1;
      r_tdi     <= 1'b0;
      r_cmd_rdy <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_busy    <= 1'b1;
`ifdef JTAG_MASTER_RTI_WAIT_EN
      r_idle    <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CmdValid && r_cmd_rdy) begin
            r_op      <= jtag_op_e'(CmdOp);
            r_len     <= CmdLen;
            r_data    <= CmdData;
            r_rsp     <= '0;
            r_idx     <= 8'd0;
            r_cmd_rdy <= 1'b0;
            r_busy    <= 1'b1;
`ifdef JTAG_MASTER_RTI_WAIT_EN
            r_idle    <= CmdIdle;
`endif
            if (w_bad) begin
              r_state   <= ST_RESP;
              r_rsp_vld <= 1'b1;
            end else begin
              // Every valid header opens with TMS=1; set it while TCK is still parked low.
              r_state <= ST_HDR;
              r_tms   <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (RspReady) begin
            r_rsp_vld <= 1'b0;
            r_cmd_rdy <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          if (w_rise && (r_state == ST_SHIFT)) begin
            r_rsp <= r_rsp | (MAX_LEN'(TDO) << r_idx);
          end
          if (w_fall) begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_tms   <= w_nxt_tms;
            r_tdi   <= w_nxt_tdi;
            if (w_nxt_state == ST_IDLE) begin
              r_cmd_rdy <= 1'b1;
              r_busy    <= 1'b0;
            end
            if (w_nxt_state == ST_RESP) begin
              r_rsp_vld <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign CmdReady = r_cmd_rdy;
  assign RspValid = r_rsp_vld;
  assign RspData  = r_rsp;
  assign TCK      = w_tck;
  assign TMS      = r_tms;
  assign TDI      = r_tdi;
  assign Busy     = r_busy;

endmodule
